// File: rtl/bram_frame_reverse.sv
// -----------------------------------------------------------------------------
// bram_frame_reverse
//
// Ping-pong BRAM buffer that time-reverses fixed-length frames. Frame n is
// written in order into one bank while frame n-1 is read back out of the
// other bank in reverse order. Typical uses are channel-order reversal in
// front of an x-engine or producing a mirrored spectrum.
//
// Ports
//   clk_i         clock, all logic on the rising edge
//   rst_i         synchronous active-high reset, overrides ce_i
//   ce_i          clock enable; every register, including the read
//                 pipeline, only advances when ce_i=1
//   sync_in_i     marks sample 0 of a frame (sampled only when ce_i=1)
//   din_i         input sample
//   sync_out_o    one ce-cycle pulse on output position 0 of a complete frame
//   dout_o        reversed output sample
//   dout_valid_o  high while dout_o carries data from a complete frame
//
// Output data lags the read address by LATENCY ce-cycles: one cycle for the
// BRAM read register, plus the optional BRAM output register when
// LATENCY=2. Sample j of a frame leaves 2*(FRAME_LEN-1-j)+1+LATENCY
// ce-cycles after it went in.
// -----------------------------------------------------------------------------
module bram_frame_reverse #(
    parameter int    WIDTH         = 128,
    parameter int    FRAME_LEN     = 1024,
    parameter int    LATENCY       = 2,
    parameter string TARGET_DEVICE = "VIRTEX5"
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ce_i,
    input  logic             sync_in_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             sync_out_o,
    output logic [WIDTH-1:0] dout_o,
    output logic             dout_valid_o
);

    localparam int            AW       = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam int            DEPTH    = 2 ** (AW + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);
    localparam logic [AW-1:0] ONE_IDX  = AW'(1);
    localparam logic [AW-1:0] ZERO_IDX = {AW{1'b0}};

    // Reject configurations the BRAM mapping cannot honour.
    if (!(LATENCY == 1 || LATENCY == 2) || (FRAME_LEN < 2) ||
        !(TARGET_DEVICE == "VIRTEX5" || TARGET_DEVICE == "VIRTEX6")) begin : g_bad_params
        $error("bram_frame_reverse: need LATENCY 1 or 2, FRAME_LEN >= 2, TARGET_DEVICE VIRTEX5 or VIRTEX6");
    end

    // Write-side state
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic          bank_q,   bank_d;
    logic [1:0]    full_q,   full_d;
    logic [AW:0]   wr_addr_s;

    // Read-side signals
    logic [AW:0]      rd_addr_s;
    logic             rd_valid_s;
    logic             rd_first_s;
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;
    logic             rd_first_q;

    // Two banks of 2**AW words, addressed as {bank, index}.
    (* ram_style = "block" *) logic [WIDTH-1:0] mem_q [DEPTH];

    // Next write address, counter, bank select and complete-frame flags.
    always_comb begin
        wr_cnt_d  = wr_cnt_q + ONE_IDX;
        bank_d    = bank_q;
        full_d    = full_q;
        wr_addr_s = {bank_q, wr_cnt_q};
        if (sync_in_i && (wr_cnt_q != ZERO_IDX)) begin
            // Forced restart: this sample becomes sample 0 of the other bank.
            // The unfinished frame is a runt, and the other bank's old frame
            // is about to be overwritten, so neither bank is complete.
            wr_addr_s = {~bank_q, ZERO_IDX};
            wr_cnt_d  = ONE_IDX;
            bank_d    = ~bank_q;
            full_d    = 2'b00;
        end else if (wr_cnt_q == LAST_IDX) begin
            // Natural wrap: current bank complete, other bank invalidated.
            // A sync_in on wr_cnt==0 lands in the default branch and is a no-op.
            wr_cnt_d  = ZERO_IDX;
            bank_d    = ~bank_q;
            full_d    = bank_q ? 2'b10 : 2'b01;
        end else begin
            wr_cnt_d  = wr_cnt_q + ONE_IDX;
        end
    end

    // Read address walks the idle bank backwards; position 0 is read when
    // the write counter is at 0 (first sample of the following frame).
    always_comb begin
        rd_addr_s  = {~bank_q, LAST_IDX - wr_cnt_q};
        rd_valid_s = full_q[~bank_q];
        rd_first_s = full_q[~bank_q] && (wr_cnt_q == ZERO_IDX);
    end

    // Write-side state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_cnt_q <= ZERO_IDX;
            bank_q   <= 1'b0;
            full_q   <= 2'b00;
        end else if (ce_i) begin
            wr_cnt_q <= wr_cnt_d;
            bank_q   <= bank_d;
            full_q   <= full_d;
        end
    end

    // BRAM write port; contents are intentionally not cleared by reset.
    always_ff @(posedge clk_i) begin
        if (ce_i && !rst_i) begin
            mem_q[wr_addr_s] <= din_i;
        end
    end

    // BRAM read port with its read register; flags travel alongside the data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q  <= {WIDTH{1'b0}};
            rd_valid_q <= 1'b0;
            rd_first_q <= 1'b0;
        end else if (ce_i) begin
            rd_data_q  <= mem_q[rd_addr_s];
            rd_valid_q <= rd_valid_s;
            rd_first_q <= rd_first_s;
        end
    end

    if (LATENCY == 2) begin : g_out_reg
        logic [WIDTH-1:0] dout_q;
        logic             valid_q;
        logic             first_q;

        // BRAM output register stage.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                dout_q  <= {WIDTH{1'b0}};
                valid_q <= 1'b0;
                first_q <= 1'b0;
            end else if (ce_i) begin
                dout_q  <= rd_data_q;
                valid_q <= rd_valid_q;
                first_q <= rd_first_q;
            end
        end

        assign dout_o       = dout_q;
        assign dout_valid_o = valid_q;
        assign sync_out_o   = first_q;
    end else begin : g_no_out_reg
        assign dout_o       = rd_data_q;
        assign dout_valid_o = rd_valid_q;
        assign sync_out_o   = rd_first_q;
    end

endmodule
